// File: rtl/pwm_timer_ctrl_if.sv
// Register-write port for pwm_timer_ctrl.
// Signals:
//   wr_valid  master -> slave  write request
//   wr_ready  slave -> master  slave accepts a write this cycle
//   wr_addr   master -> slave  register address (3 bits)
//   wr_data   master -> slave  write data (16 bits)
interface pwm_timer_ctrl_if;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pwm_timer_ctrl.sv
// Timer and configuration controller feeding a pwm_gen instance.
// Owns the prescaled period counter and the active configuration. Register
// writes land in shadow registers and are committed to the active outputs
// only at a period wrap, so pwm_gen never sees a torn configuration.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr              write port (slave): wr_valid/wr_ready/wr_addr/wr_data
//   pwm_en          active enable
//   period          active period
//   functions       active function bits
//   compare1/2      active compare values
//   count_val       current counter value
//   period_done     one-cycle pulse after a counter wrap
//   update_pending  shadow holds data not yet committed
//   wr_err          one-cycle pulse after a write to an unmapped address
module pwm_timer_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_timer_ctrl_if.slave     wr,
  output logic                pwm_en,
  output logic [CNT_W-1:0]    period,
  output logic [7:0]          functions,
  output logic [CNT_W-1:0]    compare1,
  output logic [CNT_W-1:0]    compare2,
  output logic [CNT_W-1:0]    count_val,
  output logic                period_done,
  output logic                update_pending,
  output logic                wr_err
);

  localparam int unsigned FUNC_W = 8;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_PERIOD    = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd2;
  localparam logic [2:0] ADDR_FUNCTIONS = 3'd3;
  localparam logic [2:0] ADDR_COMPARE1  = 3'd4;
  localparam logic [2:0] ADDR_COMPARE2  = 3'd5;

  // Full shadowed configuration; commit is a single struct copy.
  typedef struct packed {
    logic [CNT_W-1:0]  period;
    logic [PSC_W-1:0]  prescale;
    logic [FUNC_W-1:0] functions;
    logic [CNT_W-1:0]  compare1;
    logic [CNT_W-1:0]  compare2;
  } cfg_t;

  cfg_t             shadow_q, shadow_d;
  cfg_t             active_q, active_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic tick_c;
  logic wrap_c;
  logic accept_c;

  // Tick when the prescaler reaches the active prescale value.
  assign tick_c   = enable_q && (psc_q == active_q.prescale);
  assign wrap_c   = tick_c && (cnt_q == active_q.period);
  // Blocking writes in the wrap cycle keeps a write and a commit apart.
  // Note: period=0 with prescale=0 wraps every cycle and locks out writes.
  assign wr.wr_ready = !wrap_c;
  assign accept_c    = wr.wr_valid && !wrap_c;

  // Next-state logic: counter, prescaler, commit and register writes.
  always_comb begin
    logic cfg_wr;
    shadow_d  = shadow_q;
    active_d  = active_q;
    enable_d  = enable_q;
    cnt_d     = cnt_q;
    psc_d     = psc_q;
    pending_d = pending_q;
    done_d    = wrap_c;
    err_d     = 1'b0;
    cfg_wr    = 1'b0;

    if (!enable_q || tick_c) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end

    // Above period (only reachable while disabled) the counter rolls over at
    // its maximum without a period_done pulse.
    if (tick_c) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (wrap_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (accept_c) begin
      case (wr.wr_addr)
        ADDR_CTRL: begin
          enable_d = wr.wr_data[0];
          if (!wr.wr_data[0]) begin
            psc_d = '0;
          end
          // cnt_clr: restart the period and commit the shadow immediately.
          if (wr.wr_data[1]) begin
            cnt_d     = '0;
            psc_d     = '0;
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
        end
        ADDR_PERIOD: begin
          cfg_wr          = 1'b1;
          shadow_d.period = CNT_W'(wr.wr_data);
          if (!enable_q) active_d.period = CNT_W'(wr.wr_data);
        end
        ADDR_PRESCALE: begin
          cfg_wr            = 1'b1;
          shadow_d.prescale = PSC_W'(wr.wr_data);
          if (!enable_q) active_d.prescale = PSC_W'(wr.wr_data);
        end
        ADDR_FUNCTIONS: begin
          cfg_wr             = 1'b1;
          shadow_d.functions = FUNC_W'(wr.wr_data);
          if (!enable_q) active_d.functions = FUNC_W'(wr.wr_data);
        end
        ADDR_COMPARE1: begin
          cfg_wr            = 1'b1;
          shadow_d.compare1 = CNT_W'(wr.wr_data);
          if (!enable_q) active_d.compare1 = CNT_W'(wr.wr_data);
        end
        ADDR_COMPARE2: begin
          cfg_wr            = 1'b1;
          shadow_d.compare2 = CNT_W'(wr.wr_data);
          if (!enable_q) active_d.compare2 = CNT_W'(wr.wr_data);
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
      // While running, configuration writes wait for the next wrap.
      if (cfg_wr && enable_q) begin
        pending_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      enable_q  <= 1'b0;
      cnt_q     <= '0;
      psc_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      enable_q  <= enable_d;
      cnt_q     <= cnt_d;
      psc_q     <= psc_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign pwm_en         = enable_q;
  assign period         = active_q.period;
  assign functions      = active_q.functions;
  assign compare1       = active_q.compare1;
  assign compare2       = active_q.compare2;
  assign count_val      = cnt_q;
  assign period_done    = done_q;
  assign update_pending = pending_q;
  assign wr_err         = err_q;

endmodule
